// File: rtl/otter_mmio_pkg.sv
// Shared constants and address helper for the OTTER MMIO hub.
package otter_mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h1100_0000;
  localparam logic [31:0] SLOT_STRIDE_DEF = 32'h0000_0020;

  // Control slots sit directly after the input and output slots.
  localparam int unsigned LVL_OFS  = 0;
  localparam int unsigned PEND_OFS = 1;
  localparam int unsigned MASK_OFS = 2;

  function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input int unsigned k);
    return base + (32'(k) * stride);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, and a rising-edge pulse
// that fires in the cycle the debounced level goes high.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_c_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any return to the debounced value restarts the stability count.
  always_comb begin
    db_d     = db_q;
    cnt_d    = '0;
    rise_c_o = 1'b0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d     = sync_q;
        rise_c_o = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = db_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// Parametrised IOBUS peripheral hub: synchronised inputs, readable output
// registers, and debounced buttons feeding a maskable interrupt.
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter logic [31:0] SLOT_STRIDE = SLOT_STRIDE_DEF,
  parameter int unsigned N_IN        = 1,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  output logic [31:0]            IOBUS_IN,
  input  logic [N_IN*IN_W-1:0]   IN_DATA,
  input  logic [N_BTN-1:0]       BTN,
  output logic [N_OUT*OUT_W-1:0] OUT_DATA,
  output logic                   INTR
);

  localparam int unsigned CTRL_BASE = N_IN + N_OUT;
  localparam int unsigned LVL_SLOT  = CTRL_BASE + LVL_OFS;
  localparam int unsigned PEND_SLOT = CTRL_BASE + PEND_OFS;
  localparam int unsigned MASK_SLOT = CTRL_BASE + MASK_OFS;

  logic [N_IN*IN_W-1:0]   in_meta_q, in_sync_q;
  logic [N_OUT*OUT_W-1:0] out_q, out_d;
  logic [N_BTN-1:0]       pend_q, pend_d;
  logic [N_BTN-1:0]       mask_q, mask_d;
  logic [N_BTN-1:0]       btn_lvl;
  logic [N_BTN-1:0]       btn_rise_c;

  logic [N_IN-1:0]  in_hit_c;
  logic [N_OUT-1:0] out_hit_c;
  logic             lvl_hit_c, pend_hit_c, mask_hit_c;

  // Write data is only partially consumed when registers are narrower than 32.
  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk_i    (CLK),
      .rst_n_i  (RST_N),
      .btn_i    (BTN[b]),
      .level_o  (btn_lvl[b]),
      .rise_c_o (btn_rise_c[b])
    );
  end

  // Exact-match slot decode.
  always_comb begin
    in_hit_c  = '0;
    out_hit_c = '0;
    for (int unsigned i = 0; i < N_IN; i++)
      in_hit_c[i] = (IOBUS_ADDR == slot_addr(BASE_ADDR, SLOT_STRIDE, i));
    for (int unsigned j = 0; j < N_OUT; j++)
      out_hit_c[j] = (IOBUS_ADDR == slot_addr(BASE_ADDR, SLOT_STRIDE, N_IN + j));
    lvl_hit_c  = (IOBUS_ADDR == slot_addr(BASE_ADDR, SLOT_STRIDE, LVL_SLOT));
    pend_hit_c = (IOBUS_ADDR == slot_addr(BASE_ADDR, SLOT_STRIDE, PEND_SLOT));
    mask_hit_c = (IOBUS_ADDR == slot_addr(BASE_ADDR, SLOT_STRIDE, MASK_SLOT));
  end

  // Write path; an edge landing with a W1C on the same bit keeps the bit set.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    pend_d = pend_q;
    if (IOBUS_WR) begin
      for (int unsigned j = 0; j < N_OUT; j++)
        if (out_hit_c[j]) out_d[j*OUT_W +: OUT_W] = IOBUS_OUT[OUT_W-1:0];
      if (mask_hit_c) mask_d = IOBUS_OUT[N_BTN-1:0];
      if (pend_hit_c) pend_d = pend_q & ~IOBUS_OUT[N_BTN-1:0];
    end
    pend_d = pend_d | btn_rise_c;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      in_meta_q <= '0;
      in_sync_q <= '0;
      out_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
    end else begin
      in_meta_q <= IN_DATA;
      in_sync_q <= in_meta_q;
      out_q     <= out_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
    end
  end

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    IOBUS_IN = '0;
    for (int unsigned i = 0; i < N_IN; i++)
      if (in_hit_c[i]) IOBUS_IN = 32'(in_sync_q[i*IN_W +: IN_W]);
    for (int unsigned j = 0; j < N_OUT; j++)
      if (out_hit_c[j]) IOBUS_IN = 32'(out_q[j*OUT_W +: OUT_W]);
    if (lvl_hit_c)  IOBUS_IN = 32'(btn_lvl);
    if (pend_hit_c) IOBUS_IN = 32'(pend_q);
    if (mask_hit_c) IOBUS_IN = 32'(mask_q);
  end

  assign OUT_DATA = out_q;
  assign INTR     = |(pend_q & mask_q);

endmodule

// File: doc/otter_mmio_hub.md
# otter_mmio_hub

Parametrised memory-mapped I/O hub for the OTTER MCU IOBUS. It replaces the fixed switch/LED/seven-segment decode with N_IN input ports, N_OUT output registers with readback, and N_BTN debounced buttons. Button rising edges latch into a maskable interrupt-pending register that drives the CPU interrupt line. It sits between OTTER_MCU and the board peripherals, clocked by the MCU clock.

## Interface
- BASE_ADDR, 32'h1100_0000, address of slot 0
- SLOT_STRIDE, 32'h20, byte distance between slots
- N_IN, 1, input ports (≥1)
- IN_W, 16, width of each input port (≤32)
- N_OUT, 2, output registers (≥1)
- OUT_W, 16, width of each output register (≤32)
- N_BTN, 4, debounced buttons (1..32)
- DB_CYCLES, 4, consecutive stable cycles required to accept a button change (≥1)

Ports:
- CLK  in  1  MCU clock; all state updates on posedge
- RST_N  in  1  synchronous, active-low reset
- IOBUS_ADDR  in  32  CPU bus address
- IOBUS_OUT  in  32  CPU write data
- IOBUS_WR  in  1  CPU write strobe, one cycle per store
- IOBUS_IN  out  32  read data to CPU (combinational)
- IN_DATA  in  N_IN*IN_W  raw asynchronous inputs; port i = [i*IN_W +: IN_W]
- BTN  in  N_BTN  raw asynchronous buttons
- OUT_DATA  out  N_OUT*OUT_W  output registers; port j = [j*OUT_W +: OUT_W]
- INTR  out  1  |(pend & mask)

## Operation
- Slot k is at BASE_ADDR + k*SLOT_STRIDE. Matching is exact; any other address reads 0 and ignores writes.
  - Slots 0..N_IN-1: input i. Read-only; returns the synchronised value, zero-extended.
  - Slots N_IN..N_IN+N_OUT-1: output j. Read/write; a write stores IOBUS_OUT[OUT_W-1:0], a read returns it zero-extended.
  - Slot N_IN+N_OUT (LVL): debounced button levels. Read-only.
  - Slot N_IN+N_OUT+1 (PEND): pending bits. A write clears the bits where IOBUS_OUT is 1 (write-1-to-clear).
  - Slot N_IN+N_OUT+2 (MASK): interrupt mask. Read/write, N_BTN bits.
- With the defaults, the map is switches 0x00, LEDs 0x20, SSEG 0x40, LVL 0x60, PEND 0x80, MASK 0xA0. Existing software keeps working.
- Every IN_DATA and BTN bit passes through a 2-flop synchroniser.
- Debounce, evaluated per button every cycle (synchronised value s vs. debounced value db, counter cnt):
  - s == db: cnt←0.
  - s ≠ db and cnt == DB_CYCLES-1: db←s, cnt←0. If the new db is 1, the pending bit is set in the same cycle.
  - s ≠ db otherwise: cnt←cnt+1.
- A falling debounced edge never sets a pending bit.
- If an edge set and a W1C clear hit the same pending bit in one cycle, the set wins.
- The mask does not gate latching. Masked edges still set pending bits; only INTR is gated.

## Timing
- Reset (RST_N low at a posedge) clears all of the following to 0: output registers, mask, pending bits, db, cnt, synchronisers.
  - Result after reset: OUT_DATA=0, INTR=0, IOBUS_IN=0 for all slots.
- Reset mid-debounce discards the partial count. A button held high through reset re-debounces from 0 and raises a fresh pending bit.
- Write latency: register value is visible on OUT_DATA and readback after the IOBUS_WR edge. Read latency is 0 (combinational on IOBUS_ADDR).
- Input latency: a change on IN_DATA before edge 0 is readable after edge 1.
- Button latency: BTN goes and stays high before edge 0. db and the pending bit go high after edge DB_CYCLES+1. INTR follows in the same cycle if the mask bit is set.
- A BTN pulse seen by the synchroniser for fewer than DB_CYCLES cycles produces no change.
- INTR is a level signal. It stays high until software clears PEND or MASK.

## Structure
- Package otter_mmio_pkg holds:
  - default BASE_ADDR and SLOT_STRIDE constants
  - slot-offset localparams LVL_OFS=0, PEND_OFS=1, MASK_OFS=2, relative to N_IN+N_OUT
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse output), instantiated N_BTN times by generate.
- Input synchronisers, the address decoder, the write path and the read mux stay in the top level.

## Test plan
- Reset: RST_N=0 for 2 cycles with BTN=4'hF and IN_DATA=16'hFFFF. Required: OUT_DATA=0 and INTR=0. After release, reading 0x11000000 returns 16'hFFFF two cycles later.
- Outputs: write 0x1234 to 0x11000020 and 0xABCD_5678 to 0x11000040. Required: OUT_DATA={16'h5678,16'h1234}, readback 0x5678. A write to 0x11000024 changes nothing and reads 0.
- Debounce: DB_CYCLES=4, BTN[0] set high before edge 0. Required: LVL=1 and PEND=1 after edge 5. A 2-cycle pulse on BTN[1] leaves LVL and PEND unchanged.
- Interrupt: MASK=4'b0001, then debounced press on BTN[2]. Required: PEND=4'b0100, INTR=0. Writing MASK=4'b0100 → INTR=1. Writing 4'b0100 to PEND → INTR=0 on the next cycle.
- Collision: W1C of PEND[0] in the same cycle that BTN[0]'s debounced rise lands. Required: PEND[0]=1.
- Release: BTN[0] drops after being latched. Required: LVL[0]=0 after DB_CYCLES+2 edges; PEND[0] unchanged.
